// File: rtl/y_ctrl_pkg.sv
// Shared definitions for the multi-cycle controller.
// Holds opcode constants, FSM state encodings, ALU op codes, pc_sel codes
// and the instruction class record latched during DECODE.
package y_ctrl_pkg;

    // Supported major opcodes (ins[6:0])
    localparam logic [6:0] OPC_R   = 7'h33;
    localparam logic [6:0] OPC_I   = 7'h13;
    localparam logic [6:0] OPC_LD  = 7'h03;
    localparam logic [6:0] OPC_ST  = 7'h23;
    localparam logic [6:0] OPC_BR  = 7'h63;
    localparam logic [6:0] OPC_JAL = 7'h6F;

    localparam logic [2:0] F3_OR = 3'b110;

    // FSM states; encodings 5..7 are unused and recover to FETCH
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    // ALU operation codes
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b110;

    // Next-PC source select
    localparam logic [1:0] PCS_P4  = 2'b00;
    localparam logic [1:0] PCS_BR  = 2'b01;
    localparam logic [1:0] PCS_JMP = 2'b10;
    localparam logic [1:0] PCS_ENT = 2'b11;

    // Instruction class; K_NONE doubles as the "illegal / nothing latched" value
    typedef enum logic [2:0] {
        K_NONE = 3'd0,
        K_R    = 3'd1,
        K_I    = 3'd2,
        K_LD   = 3'd3,
        K_ST   = 3'd4,
        K_BR   = 3'd5,
        K_JAL  = 3'd6
    } kind_e;

    typedef struct packed {
        kind_e      kind;
        logic [2:0] op;
        logic       alu_src;
    } cls_t;

    localparam cls_t CLS_NONE = '{kind: K_NONE, op: ALU_ADD, alu_src: 1'b0};

endpackage

// File: rtl/y_mc_ctrl_if.sv
// Controller <-> datapath bundle.
//   Datapath -> controller : ins, zero, int_req
//   Controller -> datapath : ir_we, pc_we, pc_sel, RegWrite, ALUSrc, op,
//                            MemRead, MemWrite, Mem2Reg
//   Status                 : state, retired, illegal
// slave  = controller side, master = datapath side.
interface y_mc_ctrl_if;
    logic [31:0] ins;
    logic        zero;
    logic        int_req;

    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        RegWrite;
    logic        ALUSrc;
    logic [2:0]  op;
    logic        MemRead;
    logic        MemWrite;
    logic        Mem2Reg;

    logic [2:0]  state;
    logic [15:0] retired;
    logic        illegal;

    modport slave (
        input  ins, zero, int_req,
        output ir_we, pc_we, pc_sel, RegWrite, ALUSrc, op,
               MemRead, MemWrite, Mem2Reg, state, retired, illegal
    );

    modport master (
        output ins, zero, int_req,
        input  ir_we, pc_we, pc_sel, RegWrite, ALUSrc, op,
               MemRead, MemWrite, Mem2Reg, state, retired, illegal
    );
endinterface

// File: rtl/y_ctrl_decode.sv
// Combinational opcode/funct3 classifier.
//   i_opcode : ins[6:0]
//   i_funct3 : ins[14:12]
//   o_cls    : class, ALU op and ALU B-source for the instruction
//   o_legal  : 1 when the opcode is one the controller sequences
module y_ctrl_decode
    import y_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    output cls_t       o_cls,
    output logic       o_legal
);

    always_comb begin
        o_cls   = CLS_NONE;
        o_legal = 1'b1;
        case (i_opcode)
            OPC_R: begin
                o_cls.kind    = K_R;
                o_cls.op      = (i_funct3 == F3_OR) ? ALU_OR : ALU_ADD;
                o_cls.alu_src = 1'b0;
            end
            OPC_I: begin
                o_cls.kind    = K_I;
                o_cls.alu_src = 1'b1;
            end
            OPC_LD: begin
                o_cls.kind    = K_LD;
                o_cls.alu_src = 1'b1;
            end
            OPC_ST: begin
                o_cls.kind    = K_ST;
                o_cls.alu_src = 1'b1;
            end
            OPC_BR: begin
                o_cls.kind    = K_BR;
                o_cls.op      = ALU_SUB;
                o_cls.alu_src = 1'b0;
            end
            OPC_JAL: begin
                o_cls.kind    = K_JAL;
                o_cls.alu_src = 1'b1;
            end
            default: o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/y_mc_ctrl.sv
// Multi-cycle (FETCH/DECODE/EXEC/MEM/WB) instruction controller.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : controller side of y_mc_ctrl_if (instruction/flags in,
//           datapath strobes, state, retired count and illegal pulse out)
// Strobes are Moore-style decodes of the registered state, qualified by
// int_req in FETCH, the incoming opcode in DECODE and zero in EXEC.
module y_mc_ctrl
    import y_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    y_mc_ctrl_if.slave     bus
);

    state_e      r_state;
    cls_t        r_cls;
    logic [15:0] r_retired;

    cls_t        w_dec_cls;
    logic        w_dec_legal;
    state_e      w_state_nxt;
    logic        w_ir_we, w_pc_we, w_reg_write, w_alu_src;
    logic        w_mem_read, w_mem_write, w_mem2reg, w_illegal, w_retire;
    logic [1:0]  w_pc_sel;
    logic [2:0]  w_op;
    logic [15:0] w_retired_nxt;
    logic        w_unused;

    assign w_unused = ^{bus.ins[31:15], bus.ins[11:7]};

    y_ctrl_decode u_dec (
        .i_opcode (bus.ins[6:0]),
        .i_funct3 (bus.ins[14:12]),
        .o_cls    (w_dec_cls),
        .o_legal  (w_dec_legal)
    );

    always_comb begin
        w_state_nxt = S_FETCH;
        w_ir_we     = 1'b0;
        w_pc_we     = 1'b0;
        w_pc_sel    = PCS_P4;
        w_reg_write = 1'b0;
        w_alu_src   = 1'b0;
        w_op        = ALU_ADD;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_mem2reg   = 1'b0;
        w_illegal   = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (bus.int_req) begin
                    w_pc_we     = 1'b1;
                    w_pc_sel    = PCS_ENT;
                    w_state_nxt = S_FETCH;
                end else begin
                    w_ir_we     = 1'b1;
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_dec_legal) begin
                    w_state_nxt = S_EXEC;
                end else begin
                    // Skip the bad word: advance PC, no retire
                    w_illegal = 1'b1;
                    w_pc_we   = 1'b1;
                end
            end
            S_EXEC: begin
                w_op      = r_cls.op;
                w_alu_src = r_cls.alu_src;
                case (r_cls.kind)
                    K_R, K_I, K_JAL: w_state_nxt = S_WB;
                    K_LD, K_ST:      w_state_nxt = S_MEM;
                    K_BR: begin
                        w_pc_we  = 1'b1;
                        w_pc_sel = bus.zero ? PCS_BR : PCS_P4;
                        w_retire = 1'b1;
                    end
                    default: w_state_nxt = S_FETCH;
                endcase
            end
            S_MEM: begin
                w_op      = r_cls.op;
                w_alu_src = r_cls.alu_src;
                if (r_cls.kind == K_LD) begin
                    w_mem_read  = 1'b1;
                    w_state_nxt = S_WB;
                end else if (r_cls.kind == K_ST) begin
                    w_mem_write = 1'b1;
                    w_pc_we     = 1'b1;
                    w_retire    = 1'b1;
                end
            end
            S_WB: begin
                w_op        = r_cls.op;
                w_alu_src   = r_cls.alu_src;
                w_reg_write = 1'b1;
                // Loads keep MemRead up so memOut is stable at the write
                w_mem_read  = (r_cls.kind == K_LD);
                w_mem2reg   = (r_cls.kind == K_LD);
                w_pc_we     = 1'b1;
                w_pc_sel    = (r_cls.kind == K_JAL) ? PCS_JMP : PCS_P4;
                w_retire    = 1'b1;
            end
            default: w_state_nxt = S_FETCH;
        endcase

        // Reset kills the in-flight instruction on the very cycle it is seen
        if (!rst_n) begin
            w_ir_we     = 1'b0;
            w_pc_we     = 1'b0;
            w_pc_sel    = PCS_P4;
            w_reg_write = 1'b0;
            w_alu_src   = 1'b0;
            w_op        = ALU_ADD;
            w_mem_read  = 1'b0;
            w_mem_write = 1'b0;
            w_mem2reg   = 1'b0;
            w_illegal   = 1'b0;
            w_retire    = 1'b0;
        end
    end

    assign w_retired_nxt = r_retired + {15'd0, w_retire};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_cls     <= CLS_NONE;
            r_retired <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_retired <= w_retired_nxt;
            if (r_state == S_DECODE) r_cls <= w_dec_cls;
        end
    end

    assign bus.ir_we    = w_ir_we;
    assign bus.pc_we    = w_pc_we;
    assign bus.pc_sel   = w_pc_sel;
    assign bus.RegWrite = w_reg_write;
    assign bus.ALUSrc   = w_alu_src;
    assign bus.op       = w_op;
    assign bus.MemRead  = w_mem_read;
    assign bus.MemWrite = w_mem_write;
    assign bus.Mem2Reg  = w_mem2reg;
    assign bus.illegal  = w_illegal;
    assign bus.state    = r_state;
    assign bus.retired  = r_retired;

endmodule

// File: tb/tb_y_mc_ctrl.sv
// Directed bench for y_mc_ctrl: each step pushes the expected output
// snapshot to a queue, and the snapshot is popped and compared mid-cycle.
module tb_y_mc_ctrl;
    import y_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;
    logic [15:0] exp_ret;
    logic [31:0] q_exp[$];
    logic [31:0] obs;

    y_mc_ctrl_if bus();

    y_mc_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign obs = {bus.state, bus.ir_we, bus.pc_we, bus.pc_sel, bus.RegWrite,
                  bus.ALUSrc, bus.op, bus.MemRead, bus.MemWrite, bus.Mem2Reg,
                  bus.illegal, bus.retired};

    // Snapshot: state ir_we pc_we pc_sel RegWrite ALUSrc op MemRead MemWrite Mem2Reg illegal
    task automatic ex(input logic [2:0] st, input logic ir, input logic pw,
                      input logic [1:0] ps, input logic rw, input logic as,
                      input logic [2:0] op, input logic mr, input logic mw,
                      input logic m2r, input logic ill);
        q_exp.push_back({st, ir, pw, ps, rw, as, op, mr, mw, m2r, ill, exp_ret});
    endtask

    task automatic cyc(input string tag);
        logic [31:0] e;
        @(negedge clk);
        n_chk++;
        assert (q_exp.size() != 0) else begin
            n_fail++;
            $error("FAIL %s scoreboard empty observed=%h", tag, obs);
        end
        if (q_exp.size() != 0) begin
            e = q_exp.pop_front();
            n_chk++;
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic t_fetch_decode(input logic [31:0] w);
        bus.ins = w; bus.zero = 1'b0; bus.int_req = 1'b0;
        ex(3'd0, 1, 0, 2'b00, 0, 0, 3'b010, 0, 0, 0, 0); cyc("fetch");
        ex(3'd1, 0, 0, 2'b00, 0, 0, 3'b010, 0, 0, 0, 0); cyc("decode");
    endtask

    task automatic t_alu(input logic [31:0] w, input logic [2:0] op,
                         input logic as, input logic jal, input logic irq_exec);
        t_fetch_decode(w);
        bus.int_req = irq_exec;
        ex(3'd2, 0, 0, 2'b00, 0, as, op, 0, 0, 0, 0); cyc("alu_exec");
        bus.int_req = 1'b0;
        ex(3'd4, 0, 1, jal ? 2'b10 : 2'b00, 1, as, op, 0, 0, 0, 0); cyc("alu_wb");
        exp_ret++;
    endtask

    task automatic t_lw(input logic [31:0] w);
        t_fetch_decode(w);
        ex(3'd2, 0, 0, 2'b00, 0, 1, 3'b010, 0, 0, 0, 0); cyc("lw_exec");
        ex(3'd3, 0, 0, 2'b00, 0, 1, 3'b010, 1, 0, 0, 0); cyc("lw_mem");
        ex(3'd4, 0, 1, 2'b00, 1, 1, 3'b010, 1, 0, 1, 0); cyc("lw_wb");
        exp_ret++;
    endtask

    task automatic t_sw(input logic [31:0] w, input logic abort);
        t_fetch_decode(w);
        ex(3'd2, 0, 0, 2'b00, 0, 1, 3'b010, 0, 0, 0, 0); cyc("sw_exec");
        if (abort) begin
            rst_n = 1'b0;
            ex(3'd3, 0, 0, 2'b00, 0, 0, 3'b010, 0, 0, 0, 0); cyc("sw_abort_mem");
            exp_ret = 16'd0;
            ex(3'd0, 0, 0, 2'b00, 0, 0, 3'b010, 0, 0, 0, 0); cyc("sw_abort_rst");
            rst_n = 1'b1;
        end else begin
            ex(3'd3, 0, 1, 2'b00, 0, 1, 3'b010, 0, 1, 0, 0); cyc("sw_mem");
            exp_ret++;
        end
    endtask

    task automatic t_br(input logic [31:0] w, input logic z);
        t_fetch_decode(w);
        bus.zero = z;
        ex(3'd2, 0, 1, z ? 2'b01 : 2'b00, 0, 0, 3'b110, 0, 0, 0, 0); cyc("br_exec");
        bus.zero = 1'b0;
        exp_ret++;
    endtask

    task automatic t_int();
        bus.int_req = 1'b1;
        ex(3'd0, 0, 1, 2'b11, 0, 0, 3'b010, 0, 0, 0, 0); cyc("int_fetch");
        bus.int_req = 1'b0;
    endtask

    task automatic t_ill(input logic [31:0] w);
        bus.ins = w; bus.zero = 1'b0; bus.int_req = 1'b0;
        ex(3'd0, 1, 0, 2'b00, 0, 0, 3'b010, 0, 0, 0, 0); cyc("ill_fetch");
        ex(3'd1, 0, 1, 2'b00, 0, 0, 3'b010, 0, 0, 0, 1); cyc("ill_decode");
    endtask

    initial begin
        rst_n = 1'b0;
        bus.ins = 32'h0; bus.zero = 1'b0; bus.int_req = 1'b0;
        exp_ret = 16'd0;
        @(posedge clk);
        #1;
        ex(3'd0, 0, 0, 2'b00, 0, 0, 3'b010, 0, 0, 0, 0); cyc("reset0");
        ex(3'd0, 0, 0, 2'b00, 0, 0, 3'b010, 0, 0, 0, 0); cyc("reset1");
        rst_n = 1'b1;

        t_alu(32'h002081B3, 3'b010, 1'b0, 1'b0, 1'b1);  // add, int_req in EXEC ignored
        t_alu(32'h0020E1B3, 3'b001, 1'b0, 1'b0, 1'b0);  // or
        t_alu(32'h00108093, 3'b010, 1'b1, 1'b0, 1'b0);  // addi
        t_alu(32'h0080006F, 3'b010, 1'b1, 1'b1, 1'b0);  // jal
        t_lw(32'h0000A183);
        t_br(32'h00208463, 1'b1);
        t_br(32'h00208463, 1'b0);
        t_int();
        t_ill(32'h0000007F);
        t_sw(32'h0020A023, 1'b0);
        t_sw(32'h0020A023, 1'b1);                        // reset during MEM
        t_alu(32'h002081B3, 3'b010, 1'b0, 1'b0, 1'b0);

        // Counter wrap: preload near the top instead of 65536 branches
        force dut.r_retired = 16'hFFFE;
        exp_ret = 16'hFFFE;
        t_int();
        release dut.r_retired;
        t_br(32'h00208463, 1'b1);
        t_br(32'h00208463, 1'b0);
        t_int();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
